// File: rtl/ebn_pkg.sv
// Shared helpers for the ebn elastic buffer: pointer/count widths, wrap-aware
// pointer increment and the push/pop transfer encoding.
package ebn_pkg;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

  // Pointer width; floor of one bit keeps degenerate depths well-formed.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 32'd2) ? 32'd1 : $clog2(depth);
  endfunction

  // Advance a circular pointer, wrapping explicitly at depth-1.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

  typedef enum logic [1:0] {
    XFER_IDLE = 2'b00,
    XFER_POP  = 2'b01,
    XFER_PUSH = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

endpackage

// File: rtl/ebn_mem.sv
// DEPTH x DWIDTH storage array: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module ebn_mem #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AWIDTH = 2
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ebn.sv
// N-deep elastic buffer with registered full flag (t_ready) and registered
// valid; port occ exists only when EBN_OCC_EN is defined.
module ebn
  import ebn_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic [DWIDTH-1:0] t_data,
  input  logic              t_valid,
  output logic              t_ready,
  output logic [DWIDTH-1:0] i_data,
  output logic              i_valid,
  input  logic              i_ready
`ifdef EBN_OCC_EN
  ,
  output logic [cnt_width(DEPTH)-1:0] occ
`endif
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              t_ready_q, t_ready_d;
  logic              i_valid_q, i_valid_d;
  logic              push_c, pop_c;
  xfer_e             xfer_c;
  logic [DWIDTH-1:0] rd_data_c;

  assign push_c = t_valid & t_ready_q;
  assign pop_c  = i_valid_q & i_ready;
  assign xfer_c = xfer_e'({push_c, pop_c});

  ebn_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AWIDTH (PTR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push_c),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (t_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data_c)
  );

  // Next-state: pointers, occupancy and the two registered handshake flags.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    t_ready_d = 1'b0;
    i_valid_d = 1'b0;

    if (push_c) begin
      wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
    end
    if (pop_c) begin
      rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
    end

    case (xfer_c)
      XFER_PUSH: count_d = count_q + CNT_W'(1);
      XFER_POP:  count_d = count_q - CNT_W'(1);
      default:   count_d = count_q;
    endcase

    // Flags look at the post-update count so they are valid the next cycle.
    t_ready_d = (count_d < CNT_W'(DEPTH));
    i_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      t_ready_q <= 1'b0;
      i_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      t_ready_q <= t_ready_d;
      i_valid_q <= i_valid_d;
    end
  end

  assign t_ready = t_ready_q;
  assign i_valid = i_valid_q;
  // Gate the head word so an empty buffer never exposes stale storage.
  assign i_data  = i_valid_q ? rd_data_c : '0;

`ifdef EBN_OCC_EN
  assign occ = count_q;
`endif

`ifndef SYNTHESIS
  a_count_range : assert property (@(posedge clk) disable iff (!rstf)
    count_q <= CNT_W'(DEPTH));
  a_wr_ptr_range : assert property (@(posedge clk) disable iff (!rstf)
    32'(wr_ptr_q) < DEPTH);
  a_rd_ptr_range : assert property (@(posedge clk) disable iff (!rstf)
    32'(rd_ptr_q) < DEPTH);
  a_valid_tracks_count : assert property (@(posedge clk) disable iff (!rstf)
    i_valid_q == (count_q != '0));
`endif

endmodule

// File: tb/tb_ebn.sv
// Scoreboard bench for ebn: DEPTH=4/DWIDTH=32 and DEPTH=3/DWIDTH=8 instances
// checked against queue-based reference models.
module tb_ebn;

  logic clk = 1'b0;
  logic rstf;
  logic up;

  logic [31:0] t_data4, i_data4;
  logic        t_valid4, t_ready4, i_valid4, i_ready4;
  logic [7:0]  t_data3, i_data3;
  logic        t_valid3, t_ready3, i_valid3, i_ready3;
`ifdef EBN_OCC_EN
  logic [2:0]  occ4;
  logic [1:0]  occ3;
`endif

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] q4[$];
  logic [7:0]  q3[$];
  logic [7:0]  recv3[$];

  always #5 clk = ~clk;

  ebn #(.DWIDTH(32), .DEPTH(4)) u_dut4 (
    .clk     (clk),
    .rstf    (rstf),
    .t_data  (t_data4),
    .t_valid (t_valid4),
    .t_ready (t_ready4),
    .i_data  (i_data4),
    .i_valid (i_valid4),
    .i_ready (i_ready4)
`ifdef EBN_OCC_EN
    ,
    .occ     (occ4)
`endif
  );

  ebn #(.DWIDTH(8), .DEPTH(3)) u_dut3 (
    .clk     (clk),
    .rstf    (rstf),
    .t_data  (t_data3),
    .t_valid (t_valid3),
    .t_ready (t_ready3),
    .i_data  (i_data3),
    .i_valid (i_valid3),
    .i_ready (i_ready3)
`ifdef EBN_OCC_EN
    ,
    .occ     (occ3)
`endif
  );

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Readiness requires one rising edge with reset released.
  always @(posedge clk or negedge rstf) begin
    if (!rstf) up <= 1'b0;
    else       up <= 1'b1;
  end

  // Monitor/scoreboard for the DEPTH=4 instance, sampled mid-cycle.
  always @(negedge clk) begin
    logic exp_tr;
    logic exp_pop;
    if (!rstf) begin
      q4.delete();
    end else begin
      exp_tr  = up && (q4.size() < 4);
      exp_pop = i_ready4 && (q4.size() != 0);
      chk("d4_t_ready", 32'(t_ready4), 32'(exp_tr));
      chk("d4_i_valid", 32'(i_valid4), 32'(q4.size() != 0));
      chk("d4_i_data", i_data4, (q4.size() != 0) ? q4[0] : 32'd0);
`ifdef EBN_OCC_EN
      chk("d4_occ", 32'(occ4), 32'(q4.size()));
`endif
      if (exp_pop) void'(q4.pop_front());
      if (t_valid4 && exp_tr) q4.push_back(t_data4);
    end
  end

  // Monitor/scoreboard for the DEPTH=3 instance.
  always @(negedge clk) begin
    logic exp_tr;
    logic exp_pop;
    if (!rstf) begin
      q3.delete();
    end else begin
      exp_tr  = up && (q3.size() < 3);
      exp_pop = i_ready3 && (q3.size() != 0);
      chk("d3_t_ready", 32'(t_ready3), 32'(exp_tr));
      chk("d3_i_valid", 32'(i_valid3), 32'(q3.size() != 0));
      chk("d3_i_data", 32'(i_data3), (q3.size() != 0) ? 32'(q3[0]) : 32'd0);
`ifdef EBN_OCC_EN
      chk("d3_occ", 32'(occ3), 32'(q3.size()));
`endif
      if (i_valid3 && i_ready3) recv3.push_back(i_data3);
      if (exp_pop) void'(q3.pop_front());
      if (t_valid3 && exp_tr) q3.push_back(t_data3);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstf     = 1'b0;
    t_valid4 = 1'b1;
    t_data4  = 32'hDEAD_BEEF;
    i_ready4 = 1'b0;
    t_valid3 = 1'b0;
    t_data3  = 8'd0;
    i_ready3 = 1'b0;

    // Reset held with traffic offered.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_t_ready", 32'(t_ready4), 32'd0);
    chk("rst_i_valid", 32'(i_valid4), 32'd0);
    chk("rst_i_data", i_data4, 32'd0);

    t_valid4 = 1'b0;
    rstf     = 1'b1;
    step();
    chk("bringup_t_ready", 32'(t_ready4), 32'd1);

    // Fill to DEPTH, fifth word must be refused.
    for (int k = 0; k < 5; k++) begin
      t_valid4 = 1'b1;
      t_data4  = 32'hA0 + 32'(k);
      step();
    end
    chk("fill_t_ready", 32'(t_ready4), 32'd0);
    chk("fill_head", i_data4, 32'hA0);
`ifdef EBN_OCC_EN
    chk("fill_occ", 32'(occ4), 32'd4);
`endif

    // Drain.
    t_valid4 = 1'b0;
    i_ready4 = 1'b1;
    repeat (5) step();
    chk("drain_i_valid", 32'(i_valid4), 32'd0);
    chk("drain_i_data", i_data4, 32'd0);
    i_ready4 = 1'b0;

    // Streaming through the DEPTH=3 instance across pointer wraps.
    recv3.delete();
    i_ready3 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      t_valid3 = 1'b1;
      t_data3  = 8'(k);
      step();
    end
    t_valid3 = 1'b0;
    repeat (3) step();
    chk("stream_count", 32'(recv3.size()), 32'd20);
    for (int k = 0; k < 20; k++) begin
      if (k < recv3.size()) chk("stream_word", 32'(recv3[k]), 32'(k));
    end

    // Simultaneous push/pop offered at full.
    for (int k = 0; k < 4; k++) begin
      t_valid4 = 1'b1;
      t_data4  = 32'hB0 + 32'(k);
      step();
    end
    t_data4 = 32'hB4;
    chk("full_t_ready", 32'(t_ready4), 32'd0);
    i_ready4 = 1'b1;
    step();
    chk("sim_t_ready", 32'(t_ready4), 32'd1);
    chk("sim_head", i_data4, 32'hB1);
    i_ready4 = 1'b0;
    step();
    chk("refill_t_ready", 32'(t_ready4), 32'd0);
`ifdef EBN_OCC_EN
    chk("refill_occ", 32'(occ4), 32'd4);
`endif
    t_valid4 = 1'b0;
    i_ready4 = 1'b1;
    repeat (5) step();

    // Random backpressure with an asynchronous reset pulse mid-run.
    for (int c = 0; c < 1000; c++) begin
      t_valid4 = 1'($urandom_range(0, 1));
      i_ready4 = ($urandom_range(0, 3) != 0);
      t_data4  = $urandom;
      t_valid3 = ($urandom_range(0, 3) != 0);
      i_ready3 = 1'($urandom_range(0, 1));
      t_data3  = 8'($urandom);
      if (c == 500) begin
        #2;
        rstf = 1'b0;
        #1;
        chk("async_t_ready4", 32'(t_ready4), 32'd0);
        chk("async_i_valid4", 32'(i_valid4), 32'd0);
        chk("async_i_data4", i_data4, 32'd0);
        chk("async_t_ready3", 32'(t_ready3), 32'd0);
        chk("async_i_valid3", 32'(i_valid3), 32'd0);
        chk("async_i_data3", 32'(i_data3), 32'd0);
        @(posedge clk);
        #3;
        rstf = 1'b1;
      end
      step();
    end

    t_valid4 = 1'b0;
    t_valid3 = 1'b0;
    i_ready4 = 1'b1;
    i_ready3 = 1'b1;
    repeat (6) step();
    chk("final_i_valid4", 32'(i_valid4), 32'd0);
    chk("final_i_valid3", 32'(i_valid3), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ebn.md
# ebn

Parametrised N-deep elastic buffer, successor to the single-stage elastic register in the valid/ready pipeline library. It accepts words on a target (t_) handshake and presents them in order on an initiator (i_) handshake. Storage is a circular buffer of DEPTH entries. t_ready is a registered full flag, so no combinational path exists from i_ready to t_ready or from t_ to i_. It sits between pipeline stages that need rate decoupling or timing isolation on both the data path and the ready path.

## Interface
- DWIDTH, 32, data width in bits (≥1)
- DEPTH, 4, number of storage entries (≥2; non-power-of-2 allowed)

- clk  input  1  clock; all state updates on rising edge
- rstf  input  1  reset, asynchronous, active-low
- t_data  input  DWIDTH  incoming word
- t_valid  input  1  incoming word valid
- t_ready  output  1  buffer can accept a word this cycle
- i_data  output  DWIDTH  head-of-buffer word
- i_valid  output  1  head word valid
- i_ready  input  1  downstream accepts head word
- occ  output  $clog2(DEPTH+1)  occupancy; present only with EBN_OCC_EN

## Operation
- push = t_valid & t_ready; pop = i_valid & i_ready.
- On push, write t_data to mem[wr_ptr] and advance wr_ptr.
- On pop, advance rd_ptr.
- Pointer width is $clog2(DEPTH). Each pointer wraps from DEPTH-1 to 0; power-of-2 overflow is not relied on.
- count (width $clog2(DEPTH+1)) updates as follows:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither
- i_valid = (count != 0).
- i_data = mem[rd_ptr] when i_valid is 1, else all-zero.
- t_ready is a flop: next value = (count_next < DEPTH).
- Push and pop in the same cycle are both honoured:
  - Empty buffer: pop is impossible (i_valid=0). The push lands and the word is visible the next cycle.
  - Full buffer: push is impossible (t_ready=0). The pop frees a slot and t_ready rises the next cycle.
- Ordering is strict FIFO. No word is dropped or duplicated.
- t_data is ignored when push=0. i_data/i_valid must hold stable while i_valid=1 and i_ready=0.

## Timing
- Reset (rstf low, asynchronous) forces:
  - count=0, wr_ptr=0, rd_ptr=0
  - i_valid=0, i_data=0, t_ready=0, occ=0
- mem contents are not reset.
- The first rising clk edge with rstf high sets t_ready=1.
- Latency: a word pushed at edge N is on i_data with i_valid=1 after edge N, i.e. in cycle N+1. There is no combinational bypass.
- Throughput is 1 word/cycle while 0 < count < DEPTH.
- After a full-state pop, one idle cycle on t_ready is allowed.
- Reset asserted mid-transfer discards all contents immediately; outputs take reset values without waiting for a clock.

## Configuration
- EBN_OCC_EN defined: port occ is present and equals the registered count, the same cycle as i_valid/t_ready.
- EBN_OCC_EN undefined: port occ is absent. count still exists internally and behaviour is otherwise identical.

## Structure
- Package ebn_pkg holds:
  - the pointer-increment-with-wrap function (ptr, DEPTH) used by both pointers
  - a localparam helper for count width
- One sub-module is natural: ebn_mem, the DEPTH×DWIDTH register array with one write port and one asynchronous read port. It has no reset.
- Pointer, count and handshake logic stay in ebn.

## Test plan
- Reset/bring-up, DEPTH=4:
  - hold rstf low with t_valid=1 -> t_ready=0, i_valid=0, i_data=0
  - release rstf -> t_ready=1 after the first edge
- Fill, DEPTH=4, i_ready=0:
  - push 0xA0..0xA3 -> t_ready falls after the 4th push; occ=4
  - fifth word 0xA4 held -> not accepted
- Drain, then i_ready=1 -> i_data reads 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; then i_valid=0, i_data=0, occ=0.
- Streaming, DEPTH=3 (wrap check): t_valid=i_ready=1 continuously for 20 words 0..19 -> outputs 0..19 in order, one per cycle after the 1-cycle latency, across multiple pointer wraps.
- Simultaneous push/pop at full, DEPTH=4: full buffer, i_ready=1, t_valid=1 -> first cycle pop only, t_ready rises next cycle, count returns to 4 with order preserved.
- Random backpressure plus mid-run reset: random t_valid/i_ready for 1000 cycles against a scoreboard, with rstf pulsed low between clock edges at cycle 500 -> outputs clear asynchronously, the scoreboard is flushed, and post-reset traffic checks clean.
